// File: rtl/pixie_dma_scheduler.sv
// Display DMA scheduler for a CDP1861-style video generator.
// Paces DMA-out requests to the CDP1802 and repeats each fetched row over LINE_REPEAT scan lines.
module pixie_dma_scheduler #(
    parameter logic [15:0] START_ADDR     = 16'h0900,
    parameter int          BYTES_PER_LINE = 8,
    parameter int          FIRST_LINE     = 64,
    parameter int          LAST_LINE      = 191,
    parameter int          LINE_REPEAT    = 4,
    parameter int          INT_LINE       = 62
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_enable,
    input  logic [1:0]  SC,
    input  logic        disp_on,
    input  logic        disp_off,
    input  logic        line_start,
    input  logic [8:0]  line_num,
    output logic        DMAO,
    output logic        INT,
    output logic        EFx,
    output logic [15:0] dma_addr,
    output logic        fb_we,
    output logic [7:0]  fb_waddr,
    output logic        underrun
);

    localparam logic [7:0] BPL8   = 8'(BYTES_PER_LINE);
    localparam logic [8:0] FIRST9 = 9'(FIRST_LINE);
    localparam logic [8:0] LAST9  = 9'(LAST_LINE);
    localparam logic [8:0] REP9   = 9'(LINE_REPEAT);
    localparam logic [8:0] INT9   = 9'(INT_LINE);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, REQ, LINE_DONE} state_t;

    state_t      state;
    logic        display_en;
    logic        disp_en_nxt;
    logic [7:0]  byte_cnt;
    logic        last_row_line;
    logic        last_frame_line;
    logic        pend_req;

    logic [7:0]  addr_off;
    logic [7:0]  row_off;
    logic [7:0]  next_row_off;
    logic [15:0] row_end_addr;
    logic [8:0]  line_rel;
    logic        line_active;
    logic        efx_window;
    logic        ack;

    // disp_off dominates so a simultaneous on/off leaves the display disabled.
    always_comb begin
        disp_en_nxt = display_en;
        if (clk_enable && disp_on)  disp_en_nxt = 1'b1;
        if (clk_enable && disp_off) disp_en_nxt = 1'b0;
    end

    // All addressing lives in a 256-byte window above START_ADDR, so offsets wrap naturally.
    assign addr_off     = 8'(dma_addr - START_ADDR);
    assign row_off      = addr_off - byte_cnt;
    assign next_row_off = last_row_line ? row_off + BPL8 : row_off;
    assign row_end_addr = last_frame_line ? START_ADDR : START_ADDR + {8'h00, next_row_off};

    assign line_rel    = line_num - FIRST9;
    assign line_active = (line_num >= FIRST9) && (line_num <= LAST9);
    assign efx_window  = ((line_num >= FIRST9 - 9'd4) && (line_num <= FIRST9 - 9'd1)) ||
                         ((line_num >= LAST9 - 9'd3) && (line_num <= LAST9));
    assign ack         = clk_enable && (SC == 2'b10);

    // NOTE: every output is a flop updated with non-blocking assignments; fb_we defaults low
    // each cycle so it can only ever be a single-clock strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            display_en      <= 1'b0;
            byte_cnt        <= 8'd0;
            last_row_line   <= 1'b0;
            last_frame_line <= 1'b0;
            pend_req        <= 1'b0;
            DMAO            <= 1'b1;
            INT             <= 1'b0;
            EFx             <= 1'b1;
            dma_addr        <= START_ADDR;
            fb_we           <= 1'b0;
            fb_waddr        <= 8'd0;
            underrun        <= 1'b0;
        end else begin
            display_en <= disp_en_nxt;
            fb_we      <= 1'b0;

            // Row flags describe the line now starting; the old values still steer this cycle.
            if (line_start) begin
                EFx             <= !efx_window;
                last_row_line   <= ((line_rel % REP9) == REP9 - 9'd1);
                last_frame_line <= (line_num == LAST9);
            end

            if (!disp_en_nxt)
                INT <= 1'b0;
            else if (line_start && (line_num == INT9) && display_en)
                INT <= 1'b1;
            else if ((clk_enable && (SC == 2'b11)) || (line_start && (line_num == INT9 + 9'd2)))
                INT <= 1'b0;

            if (clk_enable && disp_on)
                underrun <= 1'b0;
            else if (line_start && (state == REQ) && disp_en_nxt)
                underrun <= 1'b1;

            if (!disp_en_nxt) begin
                state    <= IDLE;
                DMAO     <= 1'b1;
                byte_cnt <= 8'd0;
                pend_req <= 1'b0;
                dma_addr <= START_ADDR + {8'h00, row_off};
            end else begin
                case (state)
                    IDLE: begin
                        if (display_en) state <= WAIT_LINE;
                    end
                    WAIT_LINE: begin
                        if (line_start) begin
                            pend_req <= 1'b0;
                            if (line_active) begin
                                state <= REQ;
                                DMAO  <= 1'b0;
                            end
                        end else if (pend_req) begin
                            pend_req <= 1'b0;
                            state    <= REQ;
                            DMAO     <= 1'b0;
                        end
                    end
                    REQ: begin
                        if (line_start) begin
                            // Late burst: abandon it, realign to the next row, re-request next clk.
                            state    <= WAIT_LINE;
                            DMAO     <= 1'b1;
                            byte_cnt <= 8'd0;
                            pend_req <= line_active;
                            dma_addr <= row_end_addr;
                        end else if (ack) begin
                            fb_we    <= 1'b1;
                            fb_waddr <= addr_off;
                            dma_addr <= START_ADDR + {8'h00, addr_off + 8'd1};
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt + 8'd1 == BPL8) begin
                                state <= LINE_DONE;
                                DMAO  <= 1'b1;
                            end
                        end
                    end
                    LINE_DONE: begin
                        state    <= WAIT_LINE;
                        byte_cnt <= 8'd0;
                        dma_addr <= row_end_addr;
                        pend_req <= line_start && line_active;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (line_start && (line_num == FIRST9))
                dma_addr <= START_ADDR;
        end
    end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Directed self-checking bench for pixie_dma_scheduler: bursts, row repeat, full frame,
// interrupt, frame flag, underrun, display disable and mid-burst reset.
module tb_pixie_dma_scheduler;

    logic        clk;
    logic        reset_n;
    logic        clk_enable;
    logic [1:0]  SC;
    logic        disp_on;
    logic        disp_off;
    logic        line_start;
    logic [8:0]  line_num;
    logic        DMAO;
    logic        INT;
    logic        EFx;
    logic [15:0] dma_addr;
    logic        fb_we;
    logic [7:0]  fb_waddr;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    logic [7:0] last_waddr = 8'd0;

    pixie_dma_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .SC         (SC),
        .disp_on    (disp_on),
        .disp_off   (disp_off),
        .line_start (line_start),
        .line_num   (line_num),
        .DMAO       (DMAO),
        .INT        (INT),
        .EFx        (EFx),
        .dma_addr   (dma_addr),
        .fb_we      (fb_we),
        .fb_waddr   (fb_waddr),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            we_count++;
            last_waddr = fb_waddr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input int n);
        line_start = 1'b1;
        line_num   = 9'(n);
        tick();
        line_start = 1'b0;
    endtask

    // n back-to-back DMA acks expecting waddr base..base+n-1; a full line also
    // checks DMAO release and that a further ack is refused.
    task automatic do_acks(input int base, input int n);
        SC = 2'b10;
        for (int i = 0; i < n; i++) begin
            tick();
            check("ack_we", 32'(fb_we), 32'd1);
            check("ack_waddr", 32'(fb_waddr), 32'(base + i));
        end
        if (n == 8) begin
            check("dmao_release", 32'(DMAO), 32'd1);
            tick();
            check("no_ninth_ack", 32'(fb_we), 32'd0);
            SC = 2'b00;
            tick();
        end
        SC = 2'b00;
    endtask

    task automatic run_line(input int line, input int base, input int n);
        pulse_line(line);
        check("dmao_req", 32'(DMAO), 32'd0);
        do_acks(base, n);
    endtask

    task automatic check_reset_values();
        check("rst_dmao", 32'(DMAO), 32'd1);
        check("rst_int", 32'(INT), 32'd0);
        check("rst_efx", 32'(EFx), 32'd1);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_dma_addr", 32'(dma_addr), 32'h0900);
        check("rst_fb_waddr", 32'(fb_waddr), 32'd0);
    endtask

    initial begin
        int c0;
        reset_n    = 1'b0;
        clk_enable = 1'b1;
        SC         = 2'b00;
        disp_on    = 1'b0;
        disp_off   = 1'b0;
        line_start = 1'b0;
        line_num   = 9'd0;
        tick();
        tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();

        // No request without disp_on, even on a qualifying line.
        pulse_line(64);
        check("no_dma_before_on", 32'(DMAO), 32'd1);
        tick();
        check("no_dma_before_on2", 32'(DMAO), 32'd1);

        disp_on = 1'b1;
        tick();
        disp_on = 1'b0;
        tick();

        // Frame flag window and interrupt acknowledge.
        pulse_line(59);
        check("efx_59", 32'(EFx), 32'd1);
        pulse_line(60);
        check("efx_60", 32'(EFx), 32'd0);
        pulse_line(62);
        check("int_set_62", 32'(INT), 32'd1);
        clk_enable = 1'b0;
        SC = 2'b11;
        tick();
        check("int_hold_no_ce", 32'(INT), 32'd1);
        clk_enable = 1'b1;
        tick();
        check("int_clr_sc11", 32'(INT), 32'd0);
        SC = 2'b00;
        pulse_line(63);
        check("efx_63", 32'(EFx), 32'd0);

        // First row: four lines repeating offsets 0..7, then row 1 from 8.
        run_line(64, 0, 8);
        check("efx_64", 32'(EFx), 32'd1);
        run_line(65, 0, 8);
        run_line(66, 0, 8);
        run_line(67, 0, 8);
        run_line(68, 8, 8);

        // Full frame, INT left pending until line 64 clears it.
        pulse_line(62);
        check("int_set_frame", 32'(INT), 32'd1);
        pulse_line(63);
        c0 = we_count;
        for (int line = 64; line <= 191; line++) begin
            run_line(line, ((line - 64) / 4) * 8, 8);
            if (line == 64) check("int_clr_line64", 32'(INT), 32'd0);
            if (line == 187) check("efx_187", 32'(EFx), 32'd1);
            if (line == 188) check("efx_188", 32'(EFx), 32'd0);
        end
        check("frame_we_count", 32'(we_count - c0), 32'd1024);
        check("frame_last_waddr", 32'(last_waddr), 32'd255);
        check("frame_addr_wrap", 32'(dma_addr), 32'h0900);
        pulse_line(192);
        check("efx_192", 32'(EFx), 32'd1);
        check("idle_after_frame", 32'(DMAO), 32'd1);

        // Underrun at the end of row 0 lands the next line on row 1.
        run_line(64, 0, 8);
        run_line(65, 0, 8);
        run_line(66, 0, 8);
        run_line(67, 0, 5);
        pulse_line(68);
        check("underrun_set", 32'(underrun), 32'd1);
        check("underrun_dmao_drop", 32'(DMAO), 32'd1);
        check("underrun_addr", 32'(dma_addr), 32'h0908);
        tick();
        check("underrun_rereq", 32'(DMAO), 32'd0);
        do_acks(8, 8);

        // Display disabled mid-burst.
        run_line(69, 8, 3);
        disp_off = 1'b1;
        tick();
        disp_off = 1'b0;
        check("off_dmao", 32'(DMAO), 32'd1);
        c0 = we_count;
        SC = 2'b10;
        repeat (4) tick();
        SC = 2'b00;
        pulse_line(70);
        tick();
        check("off_dmao_line70", 32'(DMAO), 32'd1);
        check("off_no_we", 32'(we_count - c0), 32'd0);
        check("underrun_sticky", 32'(underrun), 32'd1);

        disp_on = 1'b1;
        tick();
        disp_on = 1'b0;
        check("underrun_clr_on", 32'(underrun), 32'd0);
        tick();

        // Asynchronous reset in the middle of a burst.
        run_line(64, 0, 4);
        SC = 2'b10;
        #2 reset_n = 1'b0;
        #1;
        check_reset_values();
        SC = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(DMAO), 32'd1);

        disp_on = 1'b1;
        tick();
        disp_on = 1'b0;
        tick();
        pulse_line(59);
        check("re_efx_59", 32'(EFx), 32'd1);
        for (int line = 60; line <= 63; line++) begin
            pulse_line(line);
            check("re_efx_window", 32'(EFx), 32'd0);
            if (line == 62) check("re_int_62", 32'(INT), 32'd1);
        end
        run_line(64, 0, 8);
        check("re_efx_64", 32'(EFx), 32'd1);
        check("re_int_64", 32'(INT), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixie_dma_scheduler.md
PIXIE_DMA_SCHEDULER -- requirements
Module: pixie_dma_scheduler

Interface
REQ-001 SHALL have parameter START_ADDR, 16'h0900, first display-RAM byte.
REQ-002 SHALL have parameter BYTES_PER_LINE, 8, DMA bytes per active line.
REQ-003 SHALL have parameter FIRST_LINE, 64, first active line; LAST_LINE, 191, last active line.
REQ-004 SHALL have parameter LINE_REPEAT, 4, lines per display row.
REQ-005 SHALL have parameter INT_LINE, 62, line on which INT asserts.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 clk_enable  in  1  CDP1802 machine-cycle strobe; SC, disp_on and disp_off sampled only when high.
REQ-009 SC  in  2  CPU state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt.
REQ-010 disp_on / disp_off  in  1 each  display enable/disable pulses.
REQ-011 line_start  in  1  one-clk pulse at start of each scan line; line_num  in  9  number of line starting.
REQ-012 DMAO  out  1  active-low DMA-out request to CPU.
REQ-013 INT  out  1  active-high interrupt request; EFx  out  1  active-low frame flag.
REQ-014 dma_addr  out  16  address of current DMA byte.
REQ-015 fb_we  out  1  one-clk write strobe per acknowledged DMA byte; fb_waddr  out  8  dma_addr - START_ADDR.
REQ-016 underrun  out  1  sticky: burst not completed before next line_start.

Function
REQ-017 States SHALL be IDLE, WAIT_LINE, REQ, LINE_DONE.
REQ-018 display_en SHALL set on clk_enable&&disp_on, clear on clk_enable&&disp_off; disp_off wins when both.
REQ-019 IDLE->WAIT_LINE SHALL occur when display_en=1; any state ->IDLE on display_en=0, with DMAO=1 on the next clk.
REQ-020 WAIT_LINE->REQ SHALL occur on line_start with FIRST_LINE<=line_num<=LAST_LINE; DMAO=0 from the following clk.
REQ-021 In REQ, each clk_enable with SC=10 SHALL be a DMA ack: fb_we=1 for one clk with current fb_waddr, then byte_cnt+1 and dma_addr+1.
REQ-022 After the BYTES_PER_LINE-th ack, DMAO SHALL be 1 on the next clk and state SHALL be LINE_DONE; no ninth ack is accepted.
REQ-023 LINE_DONE SHALL go to WAIT_LINE next clk; if (line_num-FIRST_LINE) mod LINE_REPEAT != LINE_REPEAT-1, dma_addr SHALL rewind by BYTES_PER_LINE, else hold.
REQ-024 line_start while in REQ SHALL set underrun, drop DMAO for one clk, advance dma_addr to next row start per REQ-023, then apply REQ-020 for the new line.
REQ-025 dma_addr SHALL reload START_ADDR on line_start with line_num=FIRST_LINE and after LAST_LINE; wraps START_ADDR+255 -> START_ADDR.
REQ-026 INT SHALL set on line_start with line_num=INT_LINE and display_en=1; clear on clk_enable&&SC=11, on line_start with line_num=INT_LINE+2, or display_en=0.
REQ-027 EFx SHALL be 0 for line_num in [FIRST_LINE-4, FIRST_LINE-1] and [LAST_LINE-3, LAST_LINE], else 1; updated on line_start, independent of display_en.
REQ-028 underrun SHALL clear only on reset or disp_on.
REQ-029 SC values other than 10 in REQ SHALL not advance byte_cnt; SC sampled without clk_enable SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL force IDLE, DMAO=1, INT=0, EFx=1, fb_we=0, underrun=0, display_en=0, byte_cnt=0, dma_addr=START_ADDR, fb_waddr=0, asynchronously, including mid-burst.
REQ-031 After reset release, no DMA request SHALL occur before disp_on and a qualifying line_start.

Verification
REQ-032 disp_on, line 64, 8 acks -> fb_waddr 0..7, DMAO high after 8th; lines 65-67 repeat 0..7; line 68 uses 8..15.
REQ-033 Full frame, lines 64-191, CPU always acks -> 1024 fb_we, last fb_waddr 255, dma_addr back at 16'h0900 after line 191.
REQ-034 Line 62 start -> INT=1; SC=11 with clk_enable -> INT=0 next clk; no SC=11 -> INT=0 at line 64.
REQ-035 Only 5 acks before next line_start -> underrun=1, next line fetches fb_waddr 8..15 (row boundary).
REQ-036 disp_off after 3rd ack -> DMAO=1 next clk, state IDLE, no further fb_we.
REQ-037 reset_n low mid-burst (byte 4) -> all outputs at reset values immediately; lines 60-63 EFx=0 after re-enable.
